// File: rtl/aes_gcm_tag_append_if.sv
// ============================================================================
// Module      : aes_gcm_tag_append_if
// Description : Payload-in / wire-format-out stream bundle for the tag appender.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_gcm_tag_append_if;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic [15:0]  s_keep;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic [15:0]  m_keep;
    logic         m_last;

    // slave: the appender itself; master: the surrounding core/consumer side
    modport slave (
        input  s_valid, s_data, s_keep, s_last, m_ready,
        output s_ready, m_valid, m_data, m_keep, m_last
    );
    modport master (
        output s_valid, s_data, s_keep, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_keep, m_last
    );
endinterface

`default_nettype wire

// File: rtl/aes_gcm_tag_append.sv
// ============================================================================
// Module      : aes_gcm_tag_append
// Description : Appends the 16-byte GCM tag to the ciphertext stream, packing it
//               into the free lanes of the last beat (plus one spill beat).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_gcm_tag_append (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start_i,
    input  wire logic                  append_en_i,
    input  wire logic [63:0]           len_pld_bits_i,
    input  wire logic [127:0]          tag_in_i,
    input  wire logic                  tag_valid_i,
    aes_gcm_tag_append_if.slave        strm,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PASS     = 3'd1,
        ST_WAIT_TAG = 3'd2,
        ST_EMIT_A   = 3'd3,
        ST_EMIT_B   = 3'd4
    } state_t;

    state_t         state_q;
    logic           append_q;
    logic [60:0]    nbytes_q;
    logic [60:0]    bytecnt_q;
    logic [127:0]   tag_q;
    logic           tag_held_q;
    logic [127:0]   hold_q;
    logic [4:0]     cnt_q;
    logic           m_valid_q;
    logic [127:0]   m_data_q;
    logic [15:0]    m_keep_q;
    logic           m_last_q;
    logic           done_q;
    logic           err_q;

    logic           w_out_free;
    logic           w_s_xfer;
    logic [4:0]     w_pop;
    logic [60:0]    w_bytecnt_nxt;
    logic           w_keep_bad;
    logic           w_tag_avail;
    logic [127:0]   w_tag_eff;
    logic [127:0]   w_tag_lane;
    logic [127:0]   w_beat_a;
    logic [127:0]   w_beat_b;
    logic [15:0]    w_keep_b;
    logic           w_unused_len_lsbs;

    assign w_unused_len_lsbs = ^len_pld_bits_i[2:0];

    assign w_out_free = !m_valid_q || strm.m_ready;
    assign w_s_xfer   = strm.s_valid && strm.s_ready;

    always_comb begin
        w_pop = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_pop = w_pop + {4'd0, strm.s_keep[i]};
        end
    end

    assign w_bytecnt_nxt = bytecnt_q + {56'd0, w_pop};
    assign w_keep_bad    = (strm.s_keep == 16'd0)
                        || ((strm.s_keep & (strm.s_keep + 16'd1)) != 16'd0);

    // A strobe arriving in the very cycle WAIT_TAG checks it is usable at once
    assign w_tag_avail = tag_held_q || tag_valid_i;
    assign w_tag_eff   = tag_held_q ? tag_q : tag_in_i;

    // Tag byte j sits at the MSB end of tag_in; reorder so lane j holds byte j
    always_comb begin
        w_tag_lane = '0;
        for (int i = 0; i < 16; i++) begin
            w_tag_lane[8*i +: 8] = w_tag_eff[8*(15-i) +: 8];
        end
    end

    always_comb begin
        int c;
        c        = int'(cnt_q);
        w_beat_a = '0;
        w_beat_b = '0;
        w_keep_b = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < c) begin
                w_beat_a[8*i +: 8] = hold_q[8*i +: 8];
                w_beat_b[8*i +: 8] = w_tag_lane[8*(16-c+i) +: 8];
                w_keep_b[i]        = 1'b1;
            end else begin
                w_beat_a[8*i +: 8] = w_tag_lane[8*(i-c) +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            append_q   <= 1'b0;
            nbytes_q   <= '0;
            bytecnt_q  <= '0;
            tag_q      <= '0;
            tag_held_q <= 1'b0;
            hold_q     <= '0;
            cnt_q      <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= m_valid_q && strm.m_ready && m_last_q;
            if (m_valid_q && strm.m_ready) begin
                m_valid_q <= 1'b0;
            end
            if ((state_q != ST_IDLE) && tag_valid_i && !tag_held_q) begin
                tag_q      <= tag_in_i;
                tag_held_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        append_q   <= append_en_i;
                        nbytes_q   <= len_pld_bits_i[63:3];
                        err_q      <= 1'b0;
                        bytecnt_q  <= '0;
                        cnt_q      <= '0;
                        tag_held_q <= tag_valid_i;
                        if (tag_valid_i) begin
                            tag_q <= tag_in_i;
                        end
                        if (len_pld_bits_i[63:3] == 61'd0) begin
                            if (append_en_i) begin
                                state_q <= ST_WAIT_TAG;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_PASS;
                        end
                    end
                end

                ST_PASS: begin
                    if (w_s_xfer) begin
                        bytecnt_q <= w_bytecnt_nxt;
                        if (!strm.s_last) begin
                            m_valid_q <= 1'b1;
                            m_data_q  <= strm.s_data;
                            m_keep_q  <= strm.s_keep;
                            m_last_q  <= 1'b0;
                            if (strm.s_keep != 16'hFFFF) begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            if (w_keep_bad || (w_bytecnt_nxt != nbytes_q)) begin
                                err_q <= 1'b1;
                            end
                            if (append_q) begin
                                hold_q  <= strm.s_data;
                                cnt_q   <= w_pop;
                                state_q <= ST_WAIT_TAG;
                            end else begin
                                m_valid_q <= 1'b1;
                                m_data_q  <= strm.s_data;
                                m_keep_q  <= strm.s_keep;
                                m_last_q  <= 1'b1;
                                state_q   <= ST_IDLE;
                            end
                        end
                    end
                end

                ST_WAIT_TAG: begin
                    if (w_tag_avail && w_out_free) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= w_beat_a;
                        m_keep_q  <= 16'hFFFF;
                        m_last_q  <= (cnt_q == 5'd0);
                        state_q   <= ST_EMIT_A;
                    end
                end

                ST_EMIT_A: begin
                    if (strm.m_ready) begin
                        if (m_last_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            m_valid_q <= 1'b1;
                            m_data_q  <= w_beat_b;
                            m_keep_q  <= w_keep_b;
                            m_last_q  <= 1'b1;
                            state_q   <= ST_EMIT_B;
                        end
                    end
                end

                ST_EMIT_B: begin
                    if (strm.m_ready) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign strm.s_ready = (state_q == ST_PASS) && w_out_free;
    assign strm.m_valid = m_valid_q;
    assign strm.m_data  = m_data_q;
    assign strm.m_keep  = m_keep_q;
    assign strm.m_last  = m_last_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_gcm_tag_append.sv
// ============================================================================
// Module      : tb_aes_gcm_tag_append
// Description : Self-checking bench; expected wire stream = payload ++ tag, chunked.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_gcm_tag_append;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         append_en;
    logic [63:0]  len_bits;
    logic [127:0] tag_in;
    logic         tag_valid;
    logic         busy;
    logic         done;
    logic         err;

    aes_gcm_tag_append_if ifc ();

    aes_gcm_tag_append dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .append_en_i    (append_en),
        .len_pld_bits_i (len_bits),
        .tag_in_i       (tag_in),
        .tag_valid_i    (tag_valid),
        .strm           (ifc),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    int     checks    = 0;
    int     errors    = 0;
    int     ready_pct = 100;
    int     done_cnt  = 0;
    int     sxfer_cnt = 0;
    beat_t  out_q[$];
    logic   prev_stall = 1'b0;
    beat_t  prev_b;

    initial begin
        ifc.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ifc.m_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Output monitor: collect accepted beats, count done pulses, check stall stability
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!ifc.m_valid || ifc.m_data !== prev_b.d || ifc.m_keep !== prev_b.k
                    || ifc.m_last !== prev_b.l) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b k=%h l=%0b d=%h, required v=1 k=%h l=%0b d=%h",
                             ifc.m_valid, ifc.m_keep, ifc.m_last, ifc.m_data, prev_b.k, prev_b.l, prev_b.d);
                end
            end
            if (ifc.m_valid && ifc.m_ready) begin
                out_q.push_back('{ifc.m_data, ifc.m_keep, ifc.m_last});
            end
            if (ifc.s_valid && ifc.s_ready) sxfer_cnt++;
            if (done) done_cnt++;
            prev_stall = ifc.m_valid && !ifc.m_ready;
            prev_b     = '{ifc.m_data, ifc.m_keep, ifc.m_last};
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // tag_mode: 0 = shortly after start, 1 = after last payload beat, 2 = with start
    task automatic run_packet(input bit app, input int nfield, input int nact,
                              input int tag_mode, input string name);
        logic [7:0]   pl[$];
        logic [7:0]   all[$];
        beat_t        in_beats[$];
        beat_t        exp[$];
        logic [127:0] tg;
        int           d0;
        int           s0;
        int           n;
        bit           payload_done;

        tg = rand128();
        for (int i = 0; i < nact; i++) pl.push_back(8'($urandom));
        for (int b = 0; b * 16 < nact; b++) begin
            beat_t x;
            x.d = rand128();
            x.k = '0;
            for (int i = 0; i < 16; i++) begin
                if (b * 16 + i < nact) begin
                    x.d[8*i +: 8] = pl[b*16+i];
                    x.k[i]        = 1'b1;
                end
            end
            x.l = ((b + 1) * 16 >= nact);
            in_beats.push_back(x);
        end
        if (app) begin
            all = pl;
            for (int j = 0; j < 16; j++) all.push_back(tg[127-8*j -: 8]);
            for (int b = 0; b * 16 < all.size(); b++) begin
                beat_t x;
                x.d = '0;
                x.k = '0;
                for (int i = 0; i < 16; i++) begin
                    if (b * 16 + i < all.size()) begin
                        x.d[8*i +: 8] = all[b*16+i];
                        x.k[i]        = 1'b1;
                    end
                end
                x.l = ((b + 1) * 16 >= all.size());
                exp.push_back(x);
            end
        end else begin
            exp = in_beats;
        end

        out_q.delete();
        d0           = done_cnt;
        s0           = sxfer_cnt;
        payload_done = 1'b0;

        @(posedge clk);
        #1;
        start     = 1'b1;
        append_en = app;
        len_bits  = (64'(nfield) << 3) | 64'($urandom_range(0, 7));
        if (tag_mode == 2) begin
            tag_valid = 1'b1;
            tag_in    = tg;
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        tag_valid = 1'b0;

        fork
            begin
                foreach (in_beats[b]) begin
                    ifc.s_valid = 1'b1;
                    ifc.s_data  = in_beats[b].d;
                    ifc.s_keep  = in_beats[b].k;
                    ifc.s_last  = in_beats[b].l;
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (!ifc.s_ready && n < 1000);
                    if (!ifc.s_ready) begin
                        checks++;
                        errors++;
                        $display("FAIL %s s_ready_timeout: got 0 after %0d cycles, required 1", name, n);
                    end
                    @(posedge clk);
                    #1;
                end
                ifc.s_valid  = 1'b0;
                ifc.s_last   = 1'b0;
                payload_done = 1'b1;
            end
            begin
                if (tag_mode == 1) begin
                    for (int w = 0; w < 2000 && !payload_done; w++) @(posedge clk);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #2;
                end
                if (tag_mode != 2) begin
                    tag_in    = tg;
                    tag_valid = 1'b1;
                    @(posedge clk);
                    #1;
                    tag_valid = 1'b0;
                end
                @(posedge clk);
                #1;
                tag_in    = ~tg;
                tag_valid = 1'b1;
                @(posedge clk);
                #1;
                tag_valid = 1'b0;
            end
        join

        n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);

        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d, required 1", name, done_cnt - d0);
        end
        checks++;
        if (sxfer_cnt - s0 !== in_beats.size()) begin
            errors++;
            $display("FAIL %s s_transfers: got %0d, required %0d", name, sxfer_cnt - s0, in_beats.size());
        end
        checks++;
        if (out_q.size() !== exp.size()) begin
            errors++;
            $display("FAIL %s beat_count: got %0d, required %0d", name, out_q.size(), exp.size());
        end
        for (int b = 0; b < exp.size() && b < out_q.size(); b++) begin
            checks++;
            if (out_q[b].d !== exp[b].d || out_q[b].k !== exp[b].k || out_q[b].l !== exp[b].l) begin
                errors++;
                $display("FAIL %s beat%0d: got k=%h l=%0b d=%h, required k=%h l=%0b d=%h", name, b,
                         out_q[b].k, out_q[b].l, out_q[b].d, exp[b].k, exp[b].l, exp[b].d);
            end
        end
        checks++;
        if (err !== (nfield != nact)) begin
            errors++;
            $display("FAIL %s err: got %0b, required %0b", name, err, (nfield != nact));
        end
        checks++;
        if (busy !== 1'b0 || ifc.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: got busy=%0b m_valid=%0b, required 0 0", name, busy, ifc.m_valid);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        start       = 1'b0;
        append_en   = 1'b0;
        len_bits    = '0;
        tag_in      = '0;
        tag_valid   = 1'b0;
        ifc.s_valid = 1'b0;
        ifc.s_data  = '0;
        ifc.s_keep  = '0;
        ifc.s_last  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifc.m_valid, ifc.m_last, done, err, busy, ifc.s_ready} !== 6'b0
            || ifc.m_data !== 128'd0 || ifc.m_keep !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b l=%0b done=%0b err=%0b busy=%0b rdy=%0b k=%h d=%h, required all 0",
                     ifc.m_valid, ifc.m_last, done, err, busy, ifc.s_ready, ifc.m_keep, ifc.m_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_append_tag_after_last();
        ready_pct = 100;
        run_packet(1'b1, 20, 20, 1, "t1_append20");
    endtask

    task automatic test_full_lane_tag_early();
        ready_pct = 100;
        run_packet(1'b1, 32, 32, 0, "t2_append32");
        run_packet(1'b1, 16, 16, 2, "t2_append16_tag_with_start");
    endtask

    task automatic test_zero_len();
        ready_pct = 100;
        run_packet(1'b1, 0, 0, 1, "t3_append0");
        run_packet(1'b0, 0, 0, 0, "t3_pass0");
    endtask

    task automatic test_passthrough();
        ready_pct = 100;
        run_packet(1'b0, 17, 17, 0, "t4_pass17");
    endtask

    task automatic test_backpressure();
        ready_pct = 50;
        run_packet(1'b1, 20, 20, 1, "t5_append20_bp");
        run_packet(1'b0, 40, 40, 1, "t5_pass40_bp");
        ready_pct = 100;
    endtask

    task automatic test_random();
        for (int p = 0; p < 12; p++) begin
            int  nb;
            bit  app;
            nb        = $urandom_range(0, 50);
            app       = 1'($urandom_range(0, 1));
            ready_pct = $urandom_range(30, 100);
            run_packet(app, nb, nb, $urandom_range(0, 2), $sformatf("rand%0d", p));
        end
        ready_pct = 100;
    endtask

    task automatic test_error_and_reset();
        int n;
        ready_pct = 100;
        run_packet(1'b1, 20, 24, 1, "t6_len_err");
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL t6_err_sticky: got %0b, required 1", err);
        end

        ready_pct = 0;
        repeat (3) @(posedge clk);
        #1;
        start     = 1'b1;
        append_en = 1'b1;
        len_bits  = 64'd8 << 3;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL t6_err_cleared_by_start: got %0b, required 0", err);
        end
        ifc.s_valid = 1'b1;
        ifc.s_data  = rand128();
        ifc.s_keep  = 16'h00FF;
        ifc.s_last  = 1'b1;
        tag_in      = rand128();
        tag_valid   = 1'b1;
        @(posedge clk);
        #1;
        tag_valid = 1'b0;
        n = 0;
        while (!ifc.s_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        ifc.s_valid = 1'b0;
        ifc.s_last  = 1'b0;
        n = 0;
        while (!ifc.m_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (ifc.m_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t6_emit_a_stalled: got m_valid=%0b busy=%0b, required 1 1", ifc.m_valid, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL t6_midpacket_reset: got m_valid=%0b busy=%0b done=%0b, required 0 0 0",
                     ifc.m_valid, busy, done);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        ready_pct = 100;
        repeat (2) @(posedge clk);
        run_packet(1'b1, 5, 5, 0, "t6_recover");
    endtask

    initial begin
        test_reset();
        test_append_tag_after_last();
        test_full_lane_tag_early();
        test_zero_len();
        test_passthrough();
        test_backpressure();
        test_random();
        test_error_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
